sr595_serializer: RTL and testbench



---
 rtl/sr595_serializer_pkg.sv | 16 +
 rtl/sr595_serializer_if.sv | 15 +
 rtl/sr595_serializer_tick.sv | 28 ++
 rtl/sr595_serializer.sv | 105 ++++++++++
 tb/tb_sr595_serializer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sr595_serializer_pkg.sv
// Shared display definitions: serializer FSM states and the frame width
// agreed between the display scanner and the 74HC595 serializer.
package sr595_serializer_pkg;

  localparam int SEG_W   = 8;
  localparam int AN_W    = 4;
  localparam int FRAME_W = SEG_W + AN_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

endpackage

// File: rtl/sr595_serializer_if.sv
// Valid/ready frame handshake between the display scanner and the serializer.
interface sr595_serializer_if
  import sr595_serializer_pkg::*;
#(
  parameter int DATA_W = FRAME_W
);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/sr595_serializer_tick.sv
// Reloadable 0..CLK_DIV-1 tick counter; restart forces the count back to zero
// so every timed state gets exactly CLK_DIV cycles.
module sr595_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sr595_serializer.sv
// Parallel-to-serial driver for a daisy-chained 74HC595 pair: shifts one frame
// out on DS/SHCP at a divided rate, then pulses STCP to latch it atomically.
module sr595_serializer
  import sr595_serializer_pkg::*;
#(
  parameter int DATA_W    = FRAME_W,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  sr595_serializer_if.slave  bus,
  output logic               o_ds,
  output logic               o_shcp,
  output logic               o_stcp,
  output logic               o_oe,
  output logic               o_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              tick;
  logic              restart;

  function automatic logic cur_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  assign restart     = (state_nxt != state);
  assign bus.o_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);

  sr595_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tc     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_valid) begin
          sreg_nxt    = bus.i_data;
          bit_cnt_nxt = CNT_W'(DATA_W - 1);
          state_nxt   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt == '0) begin
            state_nxt = ST_LATCH;
          end else begin
            sreg_nxt    = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            bit_cnt_nxt = bit_cnt - CNT_W'(1);
            state_nxt   = ST_SHIFT_LO;
          end
        end
      end
      ST_LATCH: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      o_ds    <= 1'b0;
      o_shcp  <= 1'b0;
      o_stcp  <= 1'b0;
      o_oe    <= 1'b1;
    end else begin
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      o_ds    <= cur_bit(sreg_nxt);
      o_shcp  <= (state_nxt == ST_SHIFT_HI);
      o_stcp  <= (state_nxt == ST_LATCH);
      if (state == ST_LATCH && state_nxt == ST_IDLE) o_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr595_serializer.sv
// Scoreboard bench for sr595_serializer: one instance MSB-first at CLK_DIV=2,
// one LSB-first at CLK_DIV=1, sharing clock and reset.
module tb_sr595_serializer;

  logic clk;
  logic rst;
  logic ds_a, shcp_a, stcp_a, oe_a, busy_a;
  logic ds_b, shcp_b, stcp_b, oe_b, busy_b;

  sr595_serializer_if #(.DATA_W(12)) if_a ();
  sr595_serializer_if #(.DATA_W(12)) if_b ();

  sr595_serializer #(.DATA_W(12), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a),
    .o_ds(ds_a), .o_shcp(shcp_a), .o_stcp(stcp_a), .o_oe(oe_a), .o_busy(busy_a)
  );

  sr595_serializer #(.DATA_W(12), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b),
    .o_ds(ds_b), .o_shcp(shcp_b), .o_stcp(stcp_b), .o_oe(oe_b), .o_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Per-instance views for the monitor
  logic [1:0]  m_shcp, m_stcp, m_ds, m_oe, m_rdy, m_vld;
  logic [11:0] m_dat [2];
  int          cdiv  [2] = '{2, 1};
  bit          msbf  [2] = '{1'b1, 1'b0};

  assign m_shcp   = {shcp_b, shcp_a};
  assign m_stcp   = {stcp_b, stcp_a};
  assign m_ds     = {ds_b, ds_a};
  assign m_oe     = {oe_b, oe_a};
  assign m_rdy    = {if_b.o_ready, if_a.o_ready};
  assign m_vld    = {if_b.i_valid, if_a.i_valid};
  assign m_dat[0] = if_a.i_data;
  assign m_dat[1] = if_b.i_data;

  bit q_a[$];
  bit q_b[$];
  bit prev_shcp [2] = '{0, 0};
  bit prev_stcp [2] = '{0, 0};
  bit in_frame  [2] = '{0, 0};
  bit latched   [2] = '{0, 0};
  int edges     [2] = '{0, 0};
  int stw       [2] = '{0, 0};
  int acc_cyc   [2] = '{0, 0};

  // Scoreboard: push the expected DS sequence on accept, pop on each SHCP rise.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
      for (int k = 0; k < 2; k++) begin
        prev_shcp[k] = 0; prev_stcp[k] = 0; in_frame[k] = 0;
        latched[k] = 0; edges[k] = 0; stw[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit e;
        int qs;
        if (in_frame[k] && m_rdy[k]) begin
          chk($sformatf("frame_len%0d", k), cyc - acc_cyc[k], 2 * 12 * cdiv[k] + cdiv[k] + 1);
          chk($sformatf("oe_after_latch%0d", k), m_oe[k], 1'b0);
          in_frame[k] = 0;
        end
        if (m_vld[k] && m_rdy[k]) begin
          for (int i = 0; i < 12; i++) begin
            e = msbf[k] ? m_dat[k][11 - i] : m_dat[k][i];
            if (k == 0) q_a.push_back(e); else q_b.push_back(e);
          end
          acc_cyc[k] = cyc;
          in_frame[k] = 1;
        end
        if (m_shcp[k] && !prev_shcp[k]) begin
          qs = (k == 0) ? q_a.size() : q_b.size();
          if (qs == 0) begin
            chk($sformatf("extra_shcp%0d", k), 1, 0);
          end else begin
            e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
            chk($sformatf("ds%0d_bit%0d", k, edges[k]), m_ds[k], e);
          end
          edges[k]++;
        end
        if (m_stcp[k]) begin
          if (!prev_stcp[k]) begin
            chk($sformatf("shcp_edges%0d", k), edges[k], 12);
            chk($sformatf("oe_in_latch%0d", k), m_oe[k], latched[k] ? 1'b0 : 1'b1);
            edges[k] = 0;
          end
          stw[k]++;
          chk($sformatf("stcp_shcp_overlap%0d", k), m_shcp[k], 1'b0);
        end else if (prev_stcp[k]) begin
          chk($sformatf("stcp_width%0d", k), stw[k], cdiv[k]);
          stw[k] = 0;
          latched[k] = 1;
        end
        prev_shcp[k] = m_shcp[k];
        prev_stcp[k] = m_stcp[k];
      end
    end
  end

  task automatic drive(input int k, input logic v, input logic [11:0] d);
    if (k == 0) begin if_a.i_valid = v; if_a.i_data = d; end
    else        begin if_b.i_valid = v; if_b.i_data = d; end
  endtask

  task automatic wait_rdy(input int k, input int budget);
    int n = 0;
    while (!m_rdy[k] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_rdy[k]) chk($sformatf("ready_timeout%0d", k), 0, 1);
  endtask

  task automatic send(input int k, input logic [11:0] d);
    wait_rdy(k, 200);
    drive(k, 1'b1, d);
    @(posedge clk); #1;
    drive(k, 1'b0, d);
  endtask

  initial begin
    int  n;
    int  guard;
    logic last;
    logic [11:0] bb [3] = '{12'h5A3, 12'h0F0, 12'hFFF};

    rst = 1'b1;
    drive(0, 1'b0, 12'h000);
    drive(1, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready_a", if_a.o_ready, 1'b1);
    chk("rst_oe_a",    oe_a,   1'b1);
    chk("rst_shcp_a",  shcp_a, 1'b0);
    chk("rst_stcp_a",  stcp_a, 1'b0);
    chk("rst_ds_a",    ds_a,   1'b0);
    chk("rst_busy_a",  busy_a, 1'b0);
    chk("rst_oe_b",    oe_b,   1'b1);

    // Single frame, MSB first
    send(0, 12'hA5C);
    wait_rdy(0, 200);

    // LSB first, single set bit
    send(1, 12'h001);
    wait_rdy(1, 200);

    // Data changes while the first frame is in flight
    wait_rdy(0, 200);
    drive(0, 1'b1, 12'hFFF);
    @(posedge clk); #1;
    drive(0, 1'b1, 12'h000);
    chk("mid_busy_a", busy_a, 1'b1);
    wait_rdy(0, 200);
    @(posedge clk); #1;
    drive(0, 1'b0, 12'h000);
    wait_rdy(0, 200);

    // Back-to-back frames at CLK_DIV=1
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, bb[i]);
      wait_rdy(1, 200);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 12'h000);
    wait_rdy(1, 200);

    // Reset in the SHIFT_HI phase of bit 5
    send(0, 12'h3C3);
    n = 0; guard = 0; last = 1'b0;
    while (n < 6 && guard < 300) begin
      @(posedge clk); #1;
      if (shcp_a && !last) n++;
      last = shcp_a;
      guard++;
    end
    if (n < 6) chk("midrst_timeout", n, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_shcp_a",  shcp_a, 1'b0);
    chk("arst_stcp_a",  stcp_a, 1'b0);
    chk("arst_oe_a",    oe_a,   1'b1);
    chk("arst_ds_a",    ds_a,   1'b0);
    chk("arst_ready_a", if_a.o_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_ready_a", if_a.o_ready, 1'b1);
    chk("post_rst_oe_a",    oe_a, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("no_stcp_after_rst", stcp_a, 1'b0);

    // Full frame after the aborted one
    send(0, 12'h5A3);
    wait_rdy(0, 200);
    repeat (3) @(posedge clk);
    #1;
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    chk("final_oe_a", oe_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
